// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: rising-edge capture on up to 16 sources,
// masking, a registered CPU request, ID latch on ack and end-of-interrupt handshake.
module irq_controller #(
  parameter int N_SRC      = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  rw,
  input  logic [3:0]            address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [N_SRC-1:0]      irq_src,
  output logic                  intr,
  input  logic                  ack
);

  localparam logic [3:0] ADDR_MASK    = 4'h0;
  localparam logic [3:0] ADDR_PENDING = 4'h1;
  localparam logic [3:0] ADDR_ID      = 4'h2;
  localparam logic [3:0] ADDR_EOI     = 4'h3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Lowest set index wins; index 0 has the highest priority.
  function automatic logic [3:0] prio_enc(input logic [N_SRC-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [N_SRC-1:0] one_hot(input logic [3:0] idx);
    logic [N_SRC-1:0] oh;
    for (int i = 0; i < N_SRC; i++) begin
      oh[i] = (4'(i) == idx);
    end
    return oh;
  endfunction

  state_t           state_q, state_d;
  logic             intr_q, intr_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] src_q, src_d;
  logic             armed_q, armed_d;
  logic             id_valid_q, id_valid_d;
  logic [3:0]       id_idx_q, id_idx_d;

  logic             wr_en_s;
  logic             eoi_wr_s;
  logic [N_SRC-1:0] set_s;
  logic [N_SRC-1:0] w1c_s;
  logic [N_SRC-1:0] ack_clr_s;
  logic [N_SRC-1:0] req_s;
  logic [3:0]       winner_s;

  assign intr = intr_q;

  // Register writes, edge capture and pending-bit update.
  always_comb begin
    wr_en_s  = ce && rw;
    eoi_wr_s = wr_en_s && (address == ADDR_EOI);
    src_d    = irq_src;
    armed_d  = 1'b1;
    req_s    = pending_q & mask_q;
    winner_s = prio_enc(req_s);

    // The first edge after reset only loads src_q, so a line held high
    // through reset is not mistaken for a fresh rising edge.
    if (armed_q) begin
      set_s = irq_src & ~src_q;
    end else begin
      set_s = {N_SRC{1'b0}};
    end

    if (wr_en_s && (address == ADDR_MASK)) begin
      mask_d = data_in[N_SRC-1:0];
    end else begin
      mask_d = mask_q;
    end

    if (wr_en_s && (address == ADDR_PENDING)) begin
      w1c_s = data_in[N_SRC-1:0];
    end else begin
      w1c_s = {N_SRC{1'b0}};
    end

    if ((state_q == REQUEST) && ack && (req_s != {N_SRC{1'b0}})) begin
      ack_clr_s = one_hot(winner_s);
    end else begin
      ack_clr_s = {N_SRC{1'b0}};
    end

    pending_d = (pending_q & ~(w1c_s | ack_clr_s)) | set_s;
  end

  // Request/acknowledge/EOI sequencing.
  always_comb begin
    state_d    = state_q;
    intr_d     = intr_q;
    id_valid_d = id_valid_q;
    id_idx_d   = id_idx_q;
    case (state_q)
      IDLE: begin
        if (req_s != {N_SRC{1'b0}}) begin
          state_d = REQUEST;
          intr_d  = 1'b1;
        end else begin
          intr_d  = 1'b0;
        end
      end
      REQUEST: begin
        if (ack && (req_s != {N_SRC{1'b0}})) begin
          state_d    = SERVICE;
          intr_d     = 1'b0;
          id_valid_d = 1'b1;
          id_idx_d   = winner_s;
        end else if (ack) begin
          state_d    = IDLE;
          intr_d     = 1'b0;
          id_valid_d = 1'b0;
          id_idx_d   = 4'd0;
        end else if (req_s == {N_SRC{1'b0}}) begin
          state_d = IDLE;
          intr_d  = 1'b0;
        end else begin
          intr_d  = 1'b1;
        end
      end
      SERVICE: begin
        intr_d = 1'b0;
        if (eoi_wr_s) begin
          state_d    = IDLE;
          id_valid_d = 1'b0;
        end else begin
          state_d = SERVICE;
        end
      end
      default: begin
        state_d = IDLE;
        intr_d  = 1'b0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      intr_q     <= 1'b0;
      mask_q     <= {N_SRC{1'b0}};
      pending_q  <= {N_SRC{1'b0}};
      src_q      <= {N_SRC{1'b0}};
      armed_q    <= 1'b0;
      id_valid_q <= 1'b0;
      id_idx_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      intr_q     <= intr_d;
      mask_q     <= mask_d;
      pending_q  <= pending_d;
      src_q      <= src_d;
      armed_q    <= armed_d;
      id_valid_q <= id_valid_d;
      id_idx_q   <= id_idx_d;
    end
  end

  // Combinational read mux; anything not selected reads zero.
  always_comb begin
    data_out = {DATA_WIDTH{1'b0}};
    if (ce && !rw) begin
      case (address)
        ADDR_MASK:    data_out[N_SRC-1:0] = mask_q;
        ADDR_PENDING: data_out[N_SRC-1:0] = pending_q;
        ADDR_ID: begin
          data_out[DATA_WIDTH-1] = id_valid_q;
          data_out[3:0]          = id_idx_q;
        end
        default:      data_out = {DATA_WIDTH{1'b0}};
      endcase
    end else begin
      data_out = {DATA_WIDTH{1'b0}};
    end
  end

endmodule
